// File: rtl/serial_mag_comparator.sv
// Serial MSB-first unsigned magnitude comparator built around a 1-bit compare stage.
// One operand bit pair is examined per clock, and the comparison stops at the first differing bit.

module serial_mag_bit_cmp (
  input  logic i_a,
  input  logic i_b,
  output logic o_gt,
  output logic o_eq,
  output logic o_lt
);

  assign o_gt = i_a & ~i_b;
  assign o_lt = ~i_a & i_b;
  assign o_eq = ~(i_a ^ i_b);

endmodule

module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic             w_bit_gt;
  logic             w_bit_eq;
  logic             w_bit_lt;
  logic             w_last_bit;

  serial_mag_bit_cmp u_bit_cmp (
    .i_a  (r_sa[WIDTH-1]),
    .i_b  (r_sb[WIDTH-1]),
    .o_gt (w_bit_gt),
    .o_eq (w_bit_eq),
    .o_lt (w_bit_lt)
  );

  assign w_last_bit = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (!w_bit_eq || w_last_bit) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result flags are cleared on acceptance and written once on the decision edge,
  // so they stay stable until the next accepted start or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_cnt <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a_in;
            r_sb  <= b_in;
            r_cnt <= CNT_W'(WIDTH - 1);
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!w_bit_eq) begin
            r_gt <= w_bit_gt;
            r_lt <= w_bit_lt;
          end else if (w_last_bit) begin
            r_eq <= 1'b1;
          end else begin
            r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
            r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator: an 8-bit instance for directed cases
// and a 4-bit instance swept over every operand pair back-to-back.

module tb_serial_mag_comparator;

  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy8, done8, gt8, eq8, lt8;
  logic       busy4, done4, gt4, eq4, lt4;

  exp_t q8[$];
  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
  );

  serial_mag_comparator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected done at %0t", name, $time);
  endtask

  // 8-bit monitor: pops the scoreboard on every done pulse and watches the
  // per-cycle flag invariants; latency counts edges after the accepting edge.
  int   lat8 = 0;
  logic prevBusy8 = 1'b0;
  logic prevDone8 = 1'b0;
  logic [2:0] last8 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lat8 = 0; prevBusy8 = 1'b0; prevDone8 = 1'b0; last8 = '0;
    end else begin
      if (busy8 && !prevBusy8) lat8 = 0;
      else if (busy8) lat8++;
      checkOutput("oneHot8", int'($countones({gt8, eq8, lt8}) <= 1), 1);
      if (prevDone8) checkOutput("busyAfterDone8", int'(busy8), 0);
      if (busy8 && !done8) checkOutput("flagsClearWhileBusy8", int'({gt8, eq8, lt8}), 0);
      if (!busy8) checkOutput("flagsHeld8", int'({gt8, eq8, lt8}), int'(last8));
      if (done8) begin
        if (q8.size() == 0) begin
          checkOutput("unexpectedDone8", 1, 0);
        end else begin
          e = q8.pop_front();
          checkOutput("result8", int'({gt8, eq8, lt8}), int'(e.flags));
          checkOutput("latency8", lat8, e.lat);
        end
        last8 = {gt8, eq8, lt8};
      end
      prevBusy8 = busy8;
      prevDone8 = done8;
    end
  end

  // 4-bit monitor, same rules as the 8-bit one.
  int   lat4 = 0;
  logic prevBusy4 = 1'b0;
  logic prevDone4 = 1'b0;
  logic [2:0] last4 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lat4 = 0; prevBusy4 = 1'b0; prevDone4 = 1'b0; last4 = '0;
    end else begin
      if (busy4 && !prevBusy4) lat4 = 0;
      else if (busy4) lat4++;
      checkOutput("oneHot4", int'($countones({gt4, eq4, lt4}) <= 1), 1);
      if (prevDone4) checkOutput("busyAfterDone4", int'(busy4), 0);
      if (busy4 && !done4) checkOutput("flagsClearWhileBusy4", int'({gt4, eq4, lt4}), 0);
      if (!busy4) checkOutput("flagsHeld4", int'({gt4, eq4, lt4}), int'(last4));
      if (done4) begin
        if (q4.size() == 0) begin
          checkOutput("unexpectedDone4", 1, 0);
        end else begin
          e = q4.pop_front();
          checkOutput("result4", int'({gt4, eq4, lt4}), int'(e.flags));
          checkOutput("latency4", lat4, e.lat);
        end
        last4 = {gt4, eq4, lt4};
      end
      prevBusy4 = busy4;
      prevDone4 = done4;
    end
  end

  task automatic waitDone8(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout(name);
  endtask

  task automatic waitDone4(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout(name);
  endtask

  // One start pulse on the 8-bit instance with a hand-computed result and latency.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] flags, input int lat, input string name);
    exp_t e;
    @(negedge clk);
    #1;
    a8 = a; b8 = b; start8 = 1'b1;
    e.flags = flags; e.lat = lat;
    q8.push_back(e);
    @(negedge clk);
    #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b;
    waitDone8(name);
  endtask

  function automatic int leadEq4(input logic [3:0] a, input logic [3:0] b);
    int k = 0;
    for (int i = 3; i >= 0; i--) begin
      if (a[i] != b[i]) break;
      k++;
    end
    return k;
  endfunction

  initial begin
    exp_t e;
    int   doneSeen;
    int   k;
    bit   idle;

    $display("[TB] serial_mag_comparator bench start");
    repeat (3) @(negedge clk);
    checkOutput("resetBusy8", int'(busy8), 0);
    checkOutput("resetDone8", int'(done8), 0);
    checkOutput("resetFlags8", int'({gt8, eq8, lt8}), 0);
    checkOutput("resetBusy4", int'(busy4), 0);
    checkOutput("resetFlags4", int'({gt4, eq4, lt4}), 0);
    #1 rst = 1'b0;

    // Directed vectors; flags are {gt,eq,lt}, latency is edges after acceptance.
    applyStimulus(8'h80, 8'h7F, 3'b100, 1, "msbDiffers");
    applyStimulus(8'h54, 8'h55, 3'b001, 8, "lsbDiffers");
    applyStimulus(8'hA5, 8'hA5, 3'b010, 8, "equalA5");
    applyStimulus(8'h00, 8'h00, 3'b010, 8, "equal00");
    applyStimulus(8'h10, 8'h20, 3'b001, 3, "bit5Differs");
    applyStimulus(8'hC3, 8'hC1, 3'b100, 7, "bit1Differs");

    // Reset on the edge right after acceptance aborts without a done pulse.
    @(negedge clk);
    #1 a8 = 8'h80; b8 = 8'h81; start8 = 1'b1;
    @(negedge clk);
    #1 start8 = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", int'(busy8), 0);
    checkOutput("abortDone", int'(done8), 0);
    checkOutput("abortFlags", int'({gt8, eq8, lt8}), 0);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);

    // A start pulse while busy is ignored and the first result survives.
    #1 a8 = 8'h54; b8 = 8'h55; start8 = 1'b1;
    e.flags = 3'b001; e.lat = 8;
    q8.push_back(e);
    @(negedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    #1 a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    #1 start8 = 1'b0;
    waitDone8("busyStartIgnored");
    repeat (4) @(negedge clk);
    checkOutput("resultHeldAfterIgnore", int'({gt8, eq8, lt8}), 3'b001);

    // Start held high through DONE is accepted on the first IDLE edge.
    #1 a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
    e.flags = 3'b100; e.lat = 1;
    q8.push_back(e);
    @(negedge clk);
    #1 a8 = 8'h10; b8 = 8'h20;
    e.flags = 3'b001; e.lat = 3;
    q8.push_back(e);
    doneSeen = 0;
    for (int i = 0; i < 40 && doneSeen < 2; i++) begin
      @(negedge clk);
      if (done8) doneSeen++;
    end
    #1 start8 = 1'b0;
    checkOutput("heldStartDonePulses", doneSeen, 2);
    repeat (4) @(negedge clk);

    // Every 4-bit pair, start held high so each is accepted on the first IDLE edge.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (!busy4) begin
            idle = 1'b1;
            break;
          end
        end
        if (!idle) reportTimeout("sweepIdle4");
        #1;
        a4 = 4'(a); b4 = 4'(b); start4 = 1'b1;
        e.flags = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
        k = leadEq4(4'(a), 4'(b));
        e.lat = (k < 4) ? k + 1 : 4;
        q4.push_back(e);
      end
    end
    @(negedge clk);
    #1 start4 = 1'b0;
    waitDone4("sweepLast4");
    repeat (4) @(negedge clk);

    checkOutput("queueEmpty8", q8.size(), 0);
    checkOutput("queueEmpty4", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
